// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
// Digit-serial two's-complement adder/subtractor. Processes DIGIT bits of the
// WIDTH-bit operands per clock through a ripple chain of full-adder cells. The
// carry is held in a register between digits, so the adder area depends only
// on DIGIT.
//
// Ports
//   clock      in   1      rising-edge clock
//   resetn     in   1      asynchronous active-low reset
//   in_valid   in   1      a, b and sub are valid
//   in_ready   out  1      operands can be accepted (IDLE only)
//   a, b       in   WIDTH  operands
//   sub        in   1      0: a+b, 1: a-b (a + ~b + 1)
//   out_valid  out  1      result/cout/overflow valid (DONE only)
//   out_ready  in   1      sink accepts the result
//   result     out  WIDTH  sum/difference modulo 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1 (sub: 1 = no borrow)
//   overflow   out  1      signed overflow
//
// WIDTH must be a multiple of DIGIT. One operation takes N = WIDTH/DIGIT cycles.
// -----------------------------------------------------------------------------
module serial_addsub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] acc_q,    acc_d;     // result being assembled, MSB side in
  logic [WIDTH-1:0] result_q, result_d;  // last completed result
  logic             carry_q,  carry_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  // Ripple chain across the current digit.
  logic [DIGIT-1:0] sum_digit;
  logic [WIDTH-1:0] sum_ext;
  logic             ripple_c;
  logic             c_into_top;  // carry into the top bit of this digit
  logic             c_out;

  always_comb begin
    // NOTE: every variable written here gets a value before any branch, so the
    // block can never hold a previous value and no latch is inferred.
    ripple_c   = carry_q;
    c_into_top = carry_q;
    sum_digit  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_into_top = ripple_c;
      sum_digit[i] = a_q[i] ^ b_q[i] ^ ripple_c;
      ripple_c     = (a_q[i] & b_q[i]) | (ripple_c & (a_q[i] ^ b_q[i]));
    end
    c_out   = ripple_c;
    sum_ext = WIDTH'(sum_digit);
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    result_d  = result_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          // Subtraction as a + ~b + 1: invert b here, inject the +1 as carry-in.
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // Digits come out LSB first, so each enters at the top and the
        // register shifts down; after N digits the result is aligned.
        acc_d   = (acc_q >> DIGIT) | (sum_ext << (WIDTH - DIGIT));
        carry_d = c_out;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          result_d = acc_d;
          cout_d   = c_out;
          ovf_d    = c_into_top ^ c_out;
          state_d  = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        // Handoff only; a new operation is taken no earlier than back in IDLE.
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset along with the FSM. This makes the
  // reset values of result/cout/overflow defined, and it leaves no X in the
  // shift registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments, so all registers update from the same
      // pre-edge values regardless of statement order.
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
